// File: rtl/fifo_rst_seq.sv
`default_nettype none
// ============================================================================
// Module  : fifo_rst_seq
// Brief   : Multi-channel FIFO reset sequencer with clear/reset/busy-wait/
//           pause windows, busy timeout and re-sequence on request.
// Revision: 1.0
// ============================================================================
module fifo_rst_seq #(
  parameter int NCH       = 4,
  parameter int CNT_W     = 8,
  parameter int CLR_CYC   = 6,
  parameter int RST_CYC   = 11,
  parameter int PAUSE_CYC = 16,
  parameter int TMO_CYC   = 255
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           REQ,
  input  logic [NCH-1:0] CH_EN,
  input  logic [NCH-1:0] BUSY,
  output logic [NCH-1:0] FIFO_RST,
  output logic           DONE,
  output logic           ERR,
  output logic [2:0]     STATE
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RESET = 3'd2,
    S_WAIT  = 3'd3,
    S_PAUSE = 3'd4,
    S_RUN   = 3'd5
  } state_t;

  // Terminal counts: a state timed for N cycles exits when the counter reads N-1.
  localparam logic [CNT_W-1:0] c_clr_last   = CNT_W'(CLR_CYC - 1);
  localparam logic [CNT_W-1:0] c_rst_last   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] c_pause_last = CNT_W'(PAUSE_CYC - 1);
  localparam logic [CNT_W-1:0] c_tmo_last   = CNT_W'(TMO_CYC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [NCH-1:0]   r_en_q;
  logic [NCH-1:0]   r_fifo_rst;
  logic             r_done;
  logic             r_err;
  logic [NCH-1:0]   w_fifo_rst;
  logic             w_busy;
  logic             w_tmo;
  logic             w_timed;
  logic             w_enter_clr;

  assign w_busy      = |(BUSY & r_en_q);
  assign w_enter_clr = (w_next == S_CLEAR) && (r_state != S_CLEAR);

  always_comb begin
    w_next     = r_state;
    w_tmo      = 1'b0;
    w_timed    = 1'b0;
    w_fifo_rst = '0;
    case (r_state)
      S_IDLE:  w_next = S_CLEAR;
      S_CLEAR: begin
        w_timed = 1'b1;
        if (r_cnt == c_clr_last) w_next = S_RESET;
      end
      S_RESET: begin
        w_timed = 1'b1;
        if (r_cnt == c_rst_last) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_timed = 1'b1;
        if (!w_busy) begin
          w_next = S_PAUSE;
        end else if (r_cnt == c_tmo_last) begin
          w_next = S_PAUSE;
          w_tmo  = 1'b1;
        end
      end
      S_PAUSE: begin
        w_timed = 1'b1;
        if (r_cnt == c_pause_last) w_next = S_RUN;
      end
      S_RUN:   if (REQ) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
    // en_q already holds the new mask by the time RESET is entered.
    case (w_next)
      S_IDLE:  w_fifo_rst = '1;
      S_RESET: w_fifo_rst = r_en_q;
      default: w_fifo_rst = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_en_q     <= '1;
      r_fifo_rst <= '1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_fifo_rst <= w_fifo_rst;
      r_done     <= (w_next == S_RUN);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_timed)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_enter_clr) begin
        r_en_q <= CH_EN;
        r_err  <= 1'b0;
      end else if (w_tmo) begin
        r_err  <= 1'b1;
      end
    end
  end

  assign FIFO_RST = r_fifo_rst;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign STATE    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rst_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_rst_seq
// Brief   : Directed bench for fifo_rst_seq with a countdown-based model.
// Revision: 1.0
// ============================================================================
module tb_fifo_rst_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       REQ = 1'b0;
  logic [3:0] CH_EN = 4'hF;
  logic [3:0] BUSY = 4'h0;
  logic [3:0] FIFO_RST;
  logic       DONE;
  logic       ERR;
  logic [2:0] STATE;

  logic       REQ1 = 1'b0;
  logic       CH_EN1 = 1'b1;
  logic       BUSY1 = 1'b0;
  logic       FIFO_RST1;
  logic       DONE1;
  logic       ERR1;
  logic [2:0] STATE1;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_rst_seq u_dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .CH_EN(CH_EN), .BUSY(BUSY),
    .FIFO_RST(FIFO_RST), .DONE(DONE), .ERR(ERR), .STATE(STATE)
  );

  fifo_rst_seq #(
    .NCH(1), .CNT_W(1), .CLR_CYC(1), .RST_CYC(1), .PAUSE_CYC(1), .TMO_CYC(1)
  ) u_dut_min (
    .CLK(CLK), .RST(RST), .REQ(REQ1), .CH_EN(CH_EN1), .BUSY(BUSY1),
    .FIFO_RST(FIFO_RST1), .DONE(DONE1), .ERR(ERR1), .STATE(STATE1)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Phase model: each timed window counts down from its length.
  localparam logic [2:0] M_IDLE = 3'd0, M_CLEAR = 3'd1, M_RESET = 3'd2,
                         M_WAIT = 3'd3, M_PAUSE = 3'd4, M_RUN = 3'd5;
  logic [2:0] m_ph;
  int         m_left;
  int         m_waited;
  logic [3:0] m_en;
  logic       m_err;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_ph <= M_IDLE; m_left <= 0; m_waited <= 0; m_en <= 4'hF; m_err <= 1'b0;
    end else begin
      case (m_ph)
        M_IDLE, M_RUN: begin
          if (m_ph == M_IDLE || REQ) begin
            m_ph <= M_CLEAR; m_left <= 6; m_en <= CH_EN; m_err <= 1'b0;
          end
        end
        M_CLEAR: if (m_left == 1) begin m_ph <= M_RESET; m_left <= 11; end
                 else m_left <= m_left - 1;
        M_RESET: if (m_left == 1) begin m_ph <= M_WAIT; m_waited <= 0; end
                 else m_left <= m_left - 1;
        M_WAIT: begin
          if ((BUSY & m_en) == 4'h0) begin
            m_ph <= M_PAUSE; m_left <= 16;
          end else if (m_waited + 1 >= 255) begin
            m_ph <= M_PAUSE; m_left <= 16; m_err <= 1'b1;
          end else begin
            m_waited <= m_waited + 1;
          end
        end
        M_PAUSE: if (m_left == 1) m_ph <= M_RUN;
                 else m_left <= m_left - 1;
        default: m_ph <= M_IDLE;
      endcase
    end
  end

  logic [3:0] exp_fr;
  always_comb begin
    exp_fr = 4'h0;
    if (m_ph == M_IDLE) exp_fr = 4'hF;
    else if (m_ph == M_RESET) exp_fr = m_en;
  end

  always @(negedge CLK)
    check("cycle{state,fifo_rst,done,err}", {23'd0, STATE, FIFO_RST, DONE, ERR},
          {23'd0, m_ph, exp_fr, (m_ph == M_RUN), m_err});

  task automatic run_seq(input logic [3:0] en, input logic [3:0] busy, input int drop,
                         input int exp_edge, input logic exp_err, input string name);
    int n;
    bit seen;
    REQ = 1'b0; CH_EN = en; BUSY = busy;
    RST = 1'b1;
    #1;
    check({name, "_rst_fifo_rst"}, FIFO_RST, 4'hF);
    check({name, "_rst_done"}, DONE, 0);
    check({name, "_rst_err"}, ERR, 0);
    check({name, "_rst_state"}, STATE, 0);
    check({name, "_min_rst_fifo_rst"}, FIFO_RST1, 1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < exp_edge + 20) begin
      @(posedge CLK);
      #1;
      n++;
      if (n == drop) BUSY = 4'h0;
      if (n <= 5) begin
        check({name, "_min_state"}, STATE1, n);
        check({name, "_min_fifo_rst"}, FIFO_RST1, (n == 2));
        check({name, "_min_done"}, DONE1, (n == 5));
      end
      if (DONE) seen = 1;
    end
    check({name, "_done_edge"}, n, exp_edge);
    check({name, "_err"}, ERR, exp_err);
  endtask

  initial begin
    int n;
    bit seen;
    #3;
    run_seq(4'hF, 4'h0, 0,  35,  1'b0, "powerup");
    run_seq(4'hF, 4'h3, 37, 54,  1'b0, "busy_wait");
    run_seq(4'hF, 4'h1, 0,  289, 1'b1, "timeout");
    run_seq(4'hE, 4'h1, 0,  35,  1'b0, "masked_busy");

    // Re-request from RUN with a new mask; a REQ during PAUSE must be ignored.
    BUSY = 4'h0; CH_EN = 4'h5; REQ = 1'b1;
    @(posedge CLK);
    #1 REQ = 1'b0;
    check("req_done_fall", DONE, 0);
    n = 0; seen = 0;
    while (!seen && n < 60) begin
      @(posedge CLK);
      #1;
      n++;
      if (n == 6)  check("req_fifo_rst_first", FIFO_RST, 4'h5);
      if (n == 16) check("req_fifo_rst_last", FIFO_RST, 4'h5);
      if (n == 17) check("req_fifo_rst_after", FIFO_RST, 4'h0);
      if (n == 20) REQ = 1'b1;
      if (n == 21) REQ = 1'b0;
      if (DONE) seen = 1;
    end
    check("req_done_edge", n, 34);

    // Reset asserted during RESET takes effect without a clock edge.
    RST = 1'b1;
    #1;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge CLK);
      #1;
    end
    check("mid_before_state", STATE, 2);
    check("mid_before_fifo_rst", FIFO_RST, 4'h5);
    RST = 1'b1;
    #1;
    check("mid_async_fifo_rst", FIFO_RST, 4'hF);
    check("mid_async_done", DONE, 0);
    check("mid_async_state", STATE, 0);
    run_seq(4'h5, 4'h0, 0, 35, 1'b0, "after_mid_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
